// File: rtl/axi_ram_responder.sv
// AXI4 slave that serves independent read and write bursts from an on-chip dual-port RAM.
// Optional AXI_RAM_DECERR_EN: addresses above the RAM range get DECERR instead of aliasing.
module axi_ram_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_WORDS_LOG2 = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic [3:0]              s_axi_awcache,
    input  logic                    s_axi_awlock,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic [3:0]              s_axi_arcache,
    input  logic                    s_axi_arlock,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [1:0]              dbg_w_state_o,
    output logic                    dbg_r_state_o
);
    // Handshake rule: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BYTE_LSB  = $clog2(STRB_W);
    localparam int IDX_HI    = MEM_WORDS_LOG2 + BYTE_LSB;
    localparam int MEM_DEPTH = 1 << MEM_WORDS_LOG2;
    localparam logic [2:0] MAX_SIZE    = 3'(BYTE_LSB);
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [2:0] eff;
        eff = (size > MAX_SIZE) ? MAX_SIZE : size;
        return (burst == BURST_FIXED) ? addr : addr + (ADDR_WIDTH'(1) << eff);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awcache, s_axi_awlock, s_axi_awprot, s_axi_awqos,
                               s_axi_arcache, s_axi_arlock, s_axi_arprot, s_axi_arqos};

    // ---------------- write channel ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  werr_q, werr_d, wdec_q, wdec_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, b_hs, w_final, w_oor, mem_we;

    assign aw_hs   = awready_q & s_axi_awvalid;
    assign w_hs    = wready_q & s_axi_wvalid;
    assign b_hs    = bvalid_q & s_axi_bready;
    assign w_final = (wcnt_q == wlen_q);
`ifdef AXI_RAM_DECERR_EN
    assign w_oor   = |waddr_q[ADDR_WIDTH-1:IDX_HI];
`else
    assign w_oor   = 1'b0;
`endif
    assign mem_we  = w_hs & ~w_oor & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wid_q     <= wid_d;
        end
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wcnt_q   <= wcnt_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
        werr_q   <= werr_d;
        wdec_q   <= wdec_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // The beat counter, not wlast, closes the burst; a misplaced wlast only taints the response.
    always_comb begin
        waddr_d  = waddr_q;
        wid_d    = wid_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        wdec_d   = wdec_q;
        if (aw_hs) begin
            waddr_d  = s_axi_awaddr;
            wid_d    = s_axi_awid;
            wlen_d   = s_axi_awlen;
            wcnt_d   = 8'd0;
            wsize_d  = s_axi_awsize;
            wburst_d = s_axi_awburst;
            werr_d   = 1'b0;
            wdec_d   = 1'b0;
        end else if (w_hs) begin
            waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
            wcnt_d  = wcnt_q + 8'd1;
            werr_d  = werr_q | (s_axi_wlast != w_final);
            wdec_d  = wdec_q | w_oor;
        end
    end

    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = wdec_d ? 2'b11 : (werr_d ? 2'b10 : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem_q[waddr_q[IDX_HI-1:BYTE_LSB]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ar_hs, r_hs, r_fetch, r_oor;

    assign ar_hs   = arready_q & s_axi_arvalid;
    assign r_hs    = rvalid_q & s_axi_rready;
    assign r_fetch = ar_hs | (r_hs & ~rlast_q);
`ifdef AXI_RAM_DECERR_EN
    assign r_oor   = |raddr_d[ADDR_WIDTH-1:IDX_HI];
`else
    assign r_oor   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
        end
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rcnt_q   <= rcnt_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        raddr_d  = raddr_q;
        rid_d    = rid_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        if (ar_hs) begin
            raddr_d  = s_axi_araddr;
            rid_d    = s_axi_arid;
            rlen_d   = s_axi_arlen;
            rcnt_d   = 8'd0;
            rsize_d  = s_axi_arsize;
            rburst_d = s_axi_arburst;
        end else if (r_hs && !rlast_q) begin
            raddr_d = next_addr(raddr_q, rsize_q, rburst_q);
            rcnt_d  = rcnt_q + 8'd1;
        end
    end

    // Data is fetched only when a new beat is presented, so it holds across rready stalls.
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = (r_state_d == R_DATA) && (rcnt_d == rlen_d);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (r_fetch) begin
            rdata_d = r_oor ? '0 : mem_q[raddr_d[IDX_HI-1:BYTE_LSB]];
            rresp_d = r_oor ? 2'b11 : 2'b00;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign dbg_w_state_o = w_state_q;
    assign dbg_r_state_o = r_state_q;
endmodule

// File: tb/tb_axi_ram_responder.sv
// Testbench for axi_ram_responder: directed AXI sequences plus random bursts checked
// against a word-array memory model with closed-form burst addressing.
module tb_axi_ram_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 0, awready, awlock = 0;
  logic [31:0] awaddr = 0;
  logic [7:0]  awid = 0, awlen = 0;
  logic [2:0]  awsize = 0, awprot = 0;
  logic [1:0]  awburst = 0;
  logic [3:0]  awcache = 0, awqos = 0;
  logic        wvalid = 0, wready, wlast = 0;
  logic [63:0] wdata = 0;
  logic [7:0]  wstrb = 0;
  logic        bvalid, bready = 0;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid = 0, arready, arlock = 0;
  logic [31:0] araddr = 0;
  logic [7:0]  arid = 0, arlen = 0;
  logic [2:0]  arsize = 0, arprot = 0;
  logic [1:0]  arburst = 0;
  logic [3:0]  arcache = 0, arqos = 0;
  logic        rvalid, rready = 0, rlast;
  logic [63:0] rdata;
  logic [7:0]  rid;
  logic [1:0]  rresp;
  logic [1:0]  dbg_w_state;
  logic        dbg_r_state;

  int errors = 0;
  int checks = 0;
  logic [63:0] model_mem [int];
  logic [63:0] wd [0:255];
  logic [7:0]  ws [0:255];

  axi_ram_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awid(awid),
    .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awcache(awcache),
    .s_axi_awlock(awlock), .s_axi_awprot(awprot), .s_axi_awqos(awqos),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arid(arid),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arcache(arcache),
    .s_axi_arlock(arlock), .s_axi_arprot(arprot), .s_axi_arqos(arqos),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rid(rid),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: beat k of a burst sits at start + k * bytes, except FIXED.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int k);
    int bytes;
    bytes = 1 << ((size > 3'd3) ? 3 : int'(size));
    return (burst == 2'b00) ? a : a + 32'(k * bytes);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef AXI_RAM_DECERR_EN
    return (a >> 17) != 0;
`else
    return (a >> 32'd31) > 1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) % 32'd16384);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bad_last,
                           input bit gaps);
    int g;
    int beat;
    bit hs;
    bit any_oor;
    logic [1:0] exp_resp;
    logic [63:0] cur;
    any_oor = 0;
    for (int k = 0; k <= int'(len); k++) begin
      logic [31:0] a;
      a = beat_addr(addr, size, burst, k);
      if (out_of_range(a)) any_oor = 1;
      else begin
        cur = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 64'h0;
        for (int b = 0; b < 8; b++) if (ws[k][b]) cur[b*8 +: 8] = wd[k][b*8 +: 8];
        model_mem[widx(a)] = cur;
      end
    end
    exp_resp = any_oor ? 2'b11 : ((bad_last && len != 0) ? 2'b10 : 2'b00);
    awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    g = 0;
    while (!awready && g < 50) begin tick(); g++; end
    chk("aw_ready_seen", awready, 1'b1);
    tick();
    awvalid = 0;
    chk("wready_after_aw", wready, 1'b1);
    beat = 0; g = 0;
    while (beat <= int'(len) && g < 2000) begin
      wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata = wd[beat]; wstrb = ws[beat];
      wlast = bad_last ? (beat == 0) : (beat == int'(len));
      hs = wvalid && wready;
      tick();
      if (hs) beat++;
      g++;
    end
    wvalid = 0; wlast = 0;
    chk("w_beats_taken", 64'(beat), 64'(int'(len) + 1));
    chk("bvalid_after_last_w", bvalid, 1'b1);
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    repeat ($urandom_range(0, 2)) tick();
    chk("bvalid_held", bvalid, 1'b1);
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_cleared", bvalid, 1'b0);
    chk("awready_after_b", awready, 1'b1);
  endtask

  // mode 0: rready always high, 1: toggles 1,0,1,0..., 2: random
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    int g;
    int beat;
    logic [31:0] a;
    logic [63:0] exp_data;
    logic [1:0] exp_resp;
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    g = 0;
    while (!arready && g < 50) begin tick(); g++; end
    chk("ar_ready_seen", arready, 1'b1);
    tick();
    arvalid = 0;
    chk("rvalid_after_ar", rvalid, 1'b1);
    beat = 0; g = 0;
    while (beat <= int'(len) && g < 2000) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
      if (mode == 0) chk("rvalid_contiguous", rvalid, 1'b1);
      if (rvalid) begin
        a = beat_addr(addr, size, burst, beat);
        exp_data = out_of_range(a) ? 64'h0 : model_mem[widx(a)];
        exp_resp = out_of_range(a) ? 2'b11 : 2'b00;
        chk("rdata", rdata, exp_data);
        chk("rid", rid, id);
        chk("rresp", rresp, exp_resp);
        chk("rlast", rlast, beat == int'(len));
        if (rready) beat++;
      end
      tick();
      g++;
    end
    rready = 0;
    chk("r_beats_taken", 64'(beat), 64'(int'(len) + 1));
    chk("arready_after_last_r", arready, 1'b1);
    chk("rvalid_after_last_r", rvalid, 1'b0);
  endtask

  initial begin
    int g;
    logic [31:0] ra;
    logic [7:0] rl;
    logic [2:0] rs;
    logic [1:0] rb;

    // reset values
    repeat (3) tick();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bid", bid, 8'h00);
    chk("rst_rid", rid, 8'h00);
    chk("rst_rdata", rdata, 64'h0);
    reset = 0;
    chk("awready_still_low", awready, 1'b0);
    tick();
    chk("awready_after_rst", awready, 1'b1);
    chk("arready_after_rst", arready, 1'b1);

    // single beat write and read back
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(32'h10000040, 8'h5A, 8'd0, 3'd3, 2'b01, 0, 0);
    axi_read(32'h10000040, 8'h33, 8'd0, 3'd3, 2'b01, 0);

    // INCR burst with toggling rready
    for (int k = 0; k < 4; k++) begin wd[k] = 64'hA0 + 64'(k); ws[k] = 8'hFF; end
    axi_write(32'h100, 8'h01, 8'd3, 3'd3, 2'b01, 0, 0);
    axi_read(32'h100, 8'h02, 8'd3, 3'd3, 2'b01, 1);

    // partial strobe
    wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'hFF;
    axi_write(32'h200, 8'h03, 8'd0, 3'd3, 2'b01, 0, 0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    axi_write(32'h200, 8'h04, 8'd0, 3'd3, 2'b01, 0, 0);
    axi_read(32'h200, 8'h05, 8'd0, 3'd3, 2'b01, 0);

    // early wlast: both beats still written, SLVERR
    wd[0] = 64'hBEEF0000; wd[1] = 64'hBEEF0001; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(32'h300, 8'h06, 8'd1, 3'd3, 2'b01, 1, 0);
    axi_read(32'h300, 8'h07, 8'd1, 3'd3, 2'b01, 0);

    // same-word read and write in one cycle returns old data
    wd[0] = 64'h1; ws[0] = 8'hFF;
    axi_write(32'h100, 8'h08, 8'd0, 3'd3, 2'b01, 0, 0);
    awaddr = 32'h100; awid = 8'h09; awlen = 0; awsize = 3; awburst = 2'b01; awvalid = 1;
    g = 0;
    while (!awready && g < 50) begin tick(); g++; end
    tick();
    awvalid = 0;
    wvalid = 1; wdata = 64'h2; wstrb = 8'hFF; wlast = 1;
    araddr = 32'h100; arid = 8'h44; arlen = 0; arsize = 3; arburst = 2'b01; arvalid = 1;
    chk("rw_wready", wready, 1'b1);
    chk("rw_arready", arready, 1'b1);
    tick();
    wvalid = 0; wlast = 0; arvalid = 0;
    chk("rw_rvalid", rvalid, 1'b1);
    chk("rw_old_data", rdata, 64'h1);
    chk("rw_bvalid", bvalid, 1'b1);
    rready = 1; bready = 1;
    tick();
    rready = 0; bready = 0;
    model_mem[widx(32'h100)] = 64'h2;
    axi_read(32'h100, 8'h45, 8'd0, 3'd3, 2'b01, 0);

`ifdef AXI_RAM_DECERR_EN
    axi_read(32'h80000000, 8'h46, 8'd0, 3'd3, 2'b01, 0);
    wd[0] = 64'hCAFE; ws[0] = 8'hFF;
    axi_write(32'h40, 8'h47, 8'd0, 3'd3, 2'b01, 0, 0);
    wd[0] = 64'hDEAD; ws[0] = 8'hFF;
    axi_write(32'h80000040, 8'h48, 8'd0, 3'd3, 2'b01, 0, 0);
    axi_read(32'h40, 8'h49, 8'd0, 3'd3, 2'b01, 0);
`endif

    // randomized bursts: full-strobe fill, random-strobe overwrite, read back
    for (int it = 0; it < 12; it++) begin
      ra = 32'($urandom_range(0, 32'h1F000));
`ifndef AXI_RAM_DECERR_EN
      ra = ra | ($urandom & 32'hFFFE0000);
`endif
      rl = 8'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 2));
      for (int k = 0; k <= int'(rl); k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
      axi_write(ra, 8'($urandom), rl, rs, rb, 0, 1);
      for (int k = 0; k <= int'(rl); k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom); end
      axi_write(ra, 8'($urandom), rl, rs, rb, $urandom_range(0, 3) == 0, 1);
`ifndef AXI_RAM_DECERR_EN
      ra = ra ^ ($urandom & 32'hFFFE0000);
`endif
      axi_read(ra, 8'($urandom), rl, rs, rb, (it % 2 == 0) ? 2 : 0);
    end

    // reset in the middle of a 4-beat read
    for (int k = 0; k < 4; k++) begin wd[k] = 64'h5000 + 64'(k); ws[k] = 8'hFF; end
    axi_write(32'h400, 8'h10, 8'd3, 3'd3, 2'b01, 0, 0);
    araddr = 32'h400; arid = 8'h11; arlen = 3; arsize = 3; arburst = 2'b01; arvalid = 1;
    g = 0;
    while (!arready && g < 50) begin tick(); g++; end
    tick();
    arvalid = 0;
    rready = 1;
    chk("mid_rdata_beat0", rdata, 64'h5000);
    tick();
    chk("mid_rdata_beat1", rdata, 64'h5001);
    reset = 1;
    tick();
    rready = 0;
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_arready", arready, 1'b0);
    reset = 0;
    tick();
    chk("post_rst_arready", arready, 1'b1);
    chk("post_rst_rvalid", rvalid, 1'b0);
    axi_read(32'h400, 8'h12, 8'd3, 3'd3, 2'b01, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 slave endpoint that terminates the master-side traffic of the FPGA address remap stage and serves it from an on-chip RAM array. It answers independent write (AW/W/B) and read (AR/R) bursts with full ID reflection, so the core's memory port can run on the zedboard without external DDR. Read and write channels run concurrently through separate state machines over a dual-port array.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, AXI data width (strobe width DATA_WIDTH/8)
- ID_WIDTH, 8, AXI ID width
- MEM_WORDS_LOG2, 14, log2 of RAM depth in DATA_WIDTH words
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- s_axi_aw{valid,ready,addr,id,len,size,burst}  in/out(ready)  1/1/ADDR_WIDTH/ID_WIDTH/8/3/2  write address channel
- s_axi_w{valid,ready,data,strb,last}  in/out(ready)  1/1/DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- s_axi_b{valid,ready,id,resp}  out/in(ready)  1/1/ID_WIDTH/2  write response channel
- s_axi_ar{valid,ready,addr,id,len,size,burst}  in/out(ready)  same widths as AW  read address channel
- s_axi_r{valid,ready,data,id,resp,last}  out/in(ready)  1/1/DATA_WIDTH/ID_WIDTH/2/1  read data channel
- awcache/awlock/awprot/awqos and AR equivalents: accepted, ignored

## Operation
- Word index = addr[MEM_WORDS_LOG2+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; upper address bits ignored unless AXI_RAM_DECERR_EN.
- Burst address update per beat: FIXED keeps address; INCR and WRAP both add 1<<size (WRAP not wrapped). size greater than log2(DATA_WIDTH/8) treated as full width.
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id/addr/len/size/burst, beat counter=0 -> W_DATA (wready=1); each W handshake writes bytes enabled by wstrb, increments counter/address; handshake with counter==len -> W_RESP (bvalid=1, bid=latched id) -> on B handshake -> W_IDLE.
- Beat count, not wlast, ends the burst. bresp=OKAY (2'b00) if wlast was high only on the final beat, otherwise SLVERR (2'b10); data still written.
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch fields -> R_DATA: rvalid=1, rid=latched id, rresp=OKAY, rlast=(counter==len); on R handshake advance; handshake with rlast -> R_IDLE.
- rdata is a registered array read of the current beat address; held stable while rvalid && !rready.
- Same-word read and write in one cycle: read returns pre-write data.
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0; FSMs to idle; awready/arready rise the cycle after reset deasserts.
- Reset mid-burst abandons the burst immediately; no B or R completion is issued for it.
- AW handshake cycle T -> wready at T+1; last W handshake at cycle U -> bvalid at U+1; next awready one cycle after B handshake.
- AR handshake cycle T -> first rvalid at T+1; with rready held high, one beat per cycle, len+1 beats contiguous; arready one cycle after last R handshake.
- No combinational path from any input valid/ready to any output; all outputs registered.
- One outstanding burst per direction; AW/AR never accepted while the corresponding FSM is busy.

## Configuration
- AXI_RAM_DECERR_EN defined: beats whose address bits above the RAM range are non-zero are decoded as out of range; writes dropped, bresp=DECERR (2'b11) if any beat was out of range (DECERR overrides SLVERR); reads return rdata=0, rresp=DECERR for that beat.
- Not defined: upper address bits ignored, accesses alias modulo RAM size, responses only OKAY/SLVERR.

## Test plan
- Single write 0x10000040, len=0, size=3, strb=0xFF, data=0x1122334455667788, wlast=1, id=0x5A -> bvalid at U+1, bid=0x5A, bresp=0; read same address id=0x33 -> rdata=0x1122334455667788, rid=0x33, rlast=1, rresp=0.
- INCR write len=3 from 0x100, data 0xA0..0xA3, then INCR read len=3 with rready toggling 1,0,1,0 -> beats 0xA0..0xA3 in order, rdata stable while stalled, rlast only on 4th beat.
- Partial strobe: write 0xFFFFFFFFFFFFFFFF then strb=0x0F data 0 -> read returns 0xFFFFFFFF00000000.
- Write len=1 with wlast on first beat -> both beats written, bresp=2'b10.
- Simultaneous read and write to word 0x20 holding 0x1 while writing 0x2 -> read returns 0x1; later read returns 0x2.
- With AXI_RAM_DECERR_EN, read from 0x80000000 (above range) -> rdata=0, rresp=2'b11; assert reset during a 4-beat read after beat 1 -> rvalid=0 next cycle, arready=1 the cycle after reset falls.
